q3a_window_monitor: RTL and testbench
=====================================

// Module: q3a_window_monitor
// PURPOSE
// - Downstream consumer of the 3-cycle window detector. Takes its per-window strobe and z
//   flag, and groups windows into frames of FRAME_WIN.
// - Per frame it reports the hit count and a run alarm (RUN_ALARM consecutive hits).
// - Results leave through a 1-entry valid/ready output register toward the status/readout logic.
// PARAMETERS
// - FRAME_WIN  default 8 : windows per frame; legal range 2..(2**CNT_W)-1
// - CNT_W      default 4 : width of the hit counter and of res_hits
// - RUN_ALARM  default 3 : consecutive-hit run length that sets the alarm; legal range 1..FRAME_WIN
// PORTS
// - clk        in   1      clock; all logic on posedge
// - reset      in   1      synchronous, active-high
// - start      in   1      arm request; honoured only in IDLE
// - stop       in   1      abort request; honoured only in ARM/RUN
// - win_stb    in   1      1-cycle pulse at each window boundary (detector cnt==0 cycle)
// - z          in   1      hit flag of the window just ended; qualified by win_stb
// - res_valid  out  1      result register holds an unconsumed frame result
// - res_ready  in   1      consumer accepts; a transfer occurs when res_valid&&res_ready
// - res_hits   out  CNT_W  number of windows in the frame with z=1
// - res_alarm  out  1      a run of >=RUN_ALARM consecutive hits occurred within the frame
// - res_drop   out  1      sticky: a completed frame was discarded because the result register was full
// - busy       out  1      1 in ARM or RUN
// BEHAVIOUR
// - Reset values: all outputs 0; state=IDLE; win_cnt=hits=run=alarm_acc=0. Reset wins over all inputs.
// - FSM states and transitions:
//   IDLE: start -> ARM. Entering ARM also clears res_drop. The result register is untouched.
//   ARM:  stop -> IDLE. Otherwise win_stb -> RUN. This first strobe only marks the start of
//         the first window; its z is ignored.
//   RUN:  stop -> IDLE; the partial frame is discarded. start is ignored.
// - On win_stb in RUN (and no stop):
//   - hits  += z
//   - run    = z ? min(run+1, RUN_ALARM) : 0
//   - alarm_acc |= (run_next == RUN_ALARM)
//   - win_cnt += 1
// - Frame end is the win_stb with win_cnt==FRAME_WIN-1. On that strobe:
//   - The result uses the updated values hits_next and alarm_acc_next.
//   - win_cnt, hits, run and alarm_acc are cleared; the run does not carry across frames.
//   - The state stays in RUN; the next strobe opens window 0 of the next frame.
// - Result register:
//   - Loads on frame end if res_valid==0, or if res_valid&&res_ready in the same cycle.
//   - Otherwise the new result is dropped, res_drop is set to 1, and the held result is unchanged.
//   - Latency: the result is visible with res_valid=1 on the cycle after the final win_stb.
//   - res_valid stays 1 until res_valid&&res_ready. res_hits and res_alarm are stable while
//     res_valid&&!res_ready.
//   - A transfer without a load in the same cycle clears res_valid to 0.
// - Arithmetic: hits never exceeds FRAME_WIN, so no overflow. The run counter saturates at RUN_ALARM.
// - Simultaneous events:
//   - stop together with the final win_stb: stop wins; no result, no drop.
//   - stop or reset never clears a pending result, except reset, which clears everything.
// - win_stb outside ARM/RUN is ignored. z without win_stb is ignored.
// - Reset mid-frame: the partial frame and any pending result are lost. The next start begins
//   a fresh frame with hits=0.
// TESTING (FRAME_WIN=4, CNT_W=4, RUN_ALARM=3)
// - Reset, start, then 5 win_stb with z=x,1,0,1,1 -> the cycle after the 5th strobe:
//   res_valid=1, res_hits=3, res_alarm=0.
// - start, 5 win_stb with z=x,1,1,1,0 -> res_hits=3, res_alarm=1.
//   Then 4 strobes with z=0 -> res_hits=0, res_alarm=0.
// - Hold res_ready=0 across two frames -> the first result is stable throughout; the second
//   frame is dropped and res_drop=1.
//   Then pulse res_ready -> res_valid=0, res_drop stays 1 until the next start from IDLE.
// - Pending result, res_ready=1 on the same cycle as the final win_stb -> the old result
//   transfers, the new result loads, res_valid stays 1, res_drop=0.
// - Assert reset after 2 windows of a frame -> all outputs 0, busy=0.
//   Then start and 5 strobes with z=x,0,0,0,1 -> res_hits=1.
// - stop on the same cycle as the final win_stb -> no result, res_drop=0, busy=0 the next
//   cycle, later win_stb ignored.

Source files
------------

// File: rtl/q3a_window_monitor.sv
// Frame monitor for the 3-cycle window detector: groups windows into frames, counts hits,
// flags runs of consecutive hits, and hands each frame result out through a 1-entry register.
module q3a_window_monitor #(
    parameter int FRAME_WIN = 8,
    parameter int CNT_W     = 4,
    parameter int RUN_ALARM = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             win_stb,
    input  logic             z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_hits,
    output logic             res_alarm,
    output logic             res_drop,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam logic [CNT_W-1:0] LAST_WIN = CNT_W'(FRAME_WIN - 1);
    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_ALARM);

    state_t           state, state_next;
    logic [CNT_W-1:0] win_cnt, hits, run;
    logic             alarm_acc;

    logic [CNT_W-1:0] hits_next, run_next;
    logic             alarm_next;
    logic             stb_run, frame_end, transfer, load, drop_now;

    // NOTE: state registers update with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output is given a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ARM;
            ARM: begin
                if (stop)         state_next = IDLE;
                else if (win_stb) state_next = RUN;
            end
            RUN:     if (stop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A stop on the same cycle as a strobe aborts the frame before that strobe counts.
    always_comb begin
        stb_run    = (state == RUN) && win_stb && !stop;
        hits_next  = hits + CNT_W'(z);
        run_next   = '0;
        if (z) run_next = (run == RUN_MAX) ? run : run + CNT_W'(1);
        alarm_next = alarm_acc || (run_next == RUN_MAX);
        frame_end  = stb_run && (win_cnt == LAST_WIN);
        transfer   = res_valid && res_ready;
        load       = frame_end && (!res_valid || res_ready);
        drop_now   = frame_end && res_valid && !res_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt   <= '0;
            hits      <= '0;
            run       <= '0;
            alarm_acc <= 1'b0;
            res_valid <= 1'b0;
            res_hits  <= '0;
            res_alarm <= 1'b0;
            res_drop  <= 1'b0;
        end else begin
            if (stb_run && !frame_end) begin
                win_cnt   <= win_cnt + CNT_W'(1);
                hits      <= hits_next;
                run       <= run_next;
                alarm_acc <= alarm_next;
            end else if (frame_end || state != RUN || stop) begin
                win_cnt   <= '0;
                hits      <= '0;
                run       <= '0;
                alarm_acc <= 1'b0;
            end

            // A transfer and a load in the same cycle keep res_valid high with the new frame.
            if (load) begin
                res_valid <= 1'b1;
                res_hits  <= hits_next;
                res_alarm <= alarm_next;
            end else if (transfer) begin
                res_valid <= 1'b0;
            end

            if (state == IDLE && start) res_drop <= 1'b0;
            else if (drop_now)          res_drop <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_q3a_window_monitor.sv
// Self-checking bench for q3a_window_monitor (FRAME_WIN=4, CNT_W=4, RUN_ALARM=3); expected
// frame results are computed from the z pattern and queued, then compared when the DUT hands them out.
module tb_q3a_window_monitor;

    localparam int FRAME_WIN = 4;
    localparam int CNT_W     = 4;
    localparam int RUN_ALARM = 3;

    typedef struct packed {
        logic [CNT_W-1:0] hits;
        logic             alarm;
    } res_t;

    logic             clk = 1'b0;
    logic             reset, start, stop, win_stb, z, res_ready;
    logic             res_valid, res_alarm, res_drop, busy;
    logic [CNT_W-1:0] res_hits;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    q3a_window_monitor #(
        .FRAME_WIN(FRAME_WIN),
        .CNT_W    (CNT_W),
        .RUN_ALARM(RUN_ALARM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .win_stb  (win_stb),
        .z        (z),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_hits (res_hits),
        .res_alarm(res_alarm),
        .res_drop (res_drop),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference: hit count is a popcount; alarm is any streak of at least RUN_ALARM ones.
    function automatic res_t frame_expect(input logic [FRAME_WIN-1:0] zs);
        res_t r;
        int   h      = 0;
        int   streak = 0;
        r.alarm = 1'b0;
        for (int i = 0; i < FRAME_WIN; i++) begin
            if (zs[i]) begin
                h++;
                streak++;
                if (streak >= RUN_ALARM) r.alarm = 1'b1;
            end else begin
                streak = 0;
            end
        end
        r.hits = CNT_W'(h);
        return r;
    endfunction

    // One strobe cycle followed by one idle cycle in which z is held high and must be ignored.
    task automatic strobe(input logic zv, input logic rdy, input logic stp);
        @(negedge clk);
        win_stb = 1'b1; z = zv; res_ready = rdy; stop = stp;
        @(negedge clk);
        win_stb = 1'b0; z = 1'b1; res_ready = 1'b0; stop = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    // zs[0] is the first window of the frame.
    task automatic run_frame(input logic [FRAME_WIN-1:0] zs, input bit expect_load);
        for (int i = 0; i < FRAME_WIN; i++) begin
            if (i == FRAME_WIN - 1 && expect_load) sb.push_back(frame_expect(zs));
            strobe(zs[i], 1'b0, 1'b0);
        end
    endtask

    task automatic consume_result(input string name);
        res_t exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, res_valid=%0b", name, res_valid);
        end else begin
            exp = sb.pop_front();
            if ({res_valid, res_hits, res_alarm} !== {1'b1, exp.hits, exp.alarm}) begin
                errors++;
                $display("FAIL %s: valid/hits/alarm got %0b/%0d/%0b want 1/%0d/%0b",
                         name, res_valid, res_hits, res_alarm, exp.hits, exp.alarm);
            end
        end
        @(negedge clk); res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_clear: res_valid got %0b want 0", name, res_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; stop = 1'b0; win_stb = 1'b1; z = 1'b1; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({res_valid, res_hits, res_alarm, res_drop, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid/hits/alarm/drop/busy got %0b/%0d/%0b/%0b/%0b want all 0",
                     res_valid, res_hits, res_alarm, res_drop, busy);
        end
        reset = 1'b0; start = 1'b0; win_stb = 1'b0; z = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy got %0b want 0", busy);
        end
    endtask

    task automatic test_basic();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy got %0b want 1", busy);
        end
        strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        run_frame(4'b1101, 1'b1);  // z = 1,0,1,1
        consume_result("basic_frame");
    endtask

    task automatic test_alarm();
        pulse_stop();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_busy: busy got %0b want 0", busy);
        end
        pulse_start();
        strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        run_frame(4'b0111, 1'b1);  // z = 1,1,1,0
        consume_result("alarm_frame");
        run_frame(4'b0000, 1'b1);
        consume_result("zero_frame");
    endtask

    task automatic test_backpressure();
        run_frame(4'b1001, 1'b1);  // held result: z = 1,0,0,1
        for (int i = 0; i < FRAME_WIN; i++) begin
            strobe(1'b1, 1'b0, 1'b0);
            checks++;
            if ({res_valid, res_hits, res_alarm} !== {1'b1, sb[0].hits, sb[0].alarm}) begin
                errors++;
                $display("FAIL held_stable_%0d: valid/hits/alarm got %0b/%0d/%0b want 1/%0d/%0b",
                         i, res_valid, res_hits, res_alarm, sb[0].hits, sb[0].alarm);
            end
        end
        checks++;
        if (res_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_set: res_drop got %0b want 1", res_drop);
        end
        consume_result("held_frame");
        checks++;
        if (res_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_sticky: res_drop got %0b want 1", res_drop);
        end
        pulse_stop();
        checks++;
        if ({res_drop, busy} !== 2'b10) begin
            errors++;
            $display("FAIL drop_after_stop: drop/busy got %0b/%0b want 1/0", res_drop, busy);
        end
        pulse_start();
        checks++;
        if ({res_drop, busy} !== 2'b01) begin
            errors++;
            $display("FAIL drop_clear_on_start: drop/busy got %0b/%0b want 0/1", res_drop, busy);
        end
    endtask

    task automatic test_back_to_back();
        res_t old_res;
        logic [FRAME_WIN-1:0] zs = 4'b1111;
        strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        run_frame(4'b0110, 1'b1);  // pending: z = 0,1,1,0
        for (int i = 0; i < FRAME_WIN - 1; i++) strobe(zs[i], 1'b0, 1'b0);
        old_res = sb.pop_front();
        checks++;
        if ({res_valid, res_hits, res_alarm} !== {1'b1, old_res.hits, old_res.alarm}) begin
            errors++;
            $display("FAIL b2b_old: valid/hits/alarm got %0b/%0d/%0b want 1/%0d/%0b",
                     res_valid, res_hits, res_alarm, old_res.hits, old_res.alarm);
        end
        sb.push_back(frame_expect(zs));
        strobe(zs[FRAME_WIN-1], 1'b1, 1'b0);
        checks++;
        if (res_drop !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_drop: res_drop got %0b want 0", res_drop);
        end
        consume_result("b2b_new");
    endtask

    task automatic test_reset_mid();
        run_frame(4'b0001, 1'b1);  // left pending, then lost to reset
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        sb.delete();
        checks++;
        if ({res_valid, res_hits, res_alarm, res_drop, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid/hits/alarm/drop/busy got %0b/%0d/%0b/%0b/%0b want all 0",
                     res_valid, res_hits, res_alarm, res_drop, busy);
        end
        reset = 1'b0;
        pulse_start();
        strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        run_frame(4'b1000, 1'b1);  // z = 0,0,0,1
        consume_result("after_reset_frame");
    endtask

    task automatic test_stop_final();
        run_frame(4'b1100, 1'b1);  // pending: z = 0,0,1,1
        for (int i = 0; i < FRAME_WIN - 1; i++) strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b1);
        checks++;
        if ({res_valid, res_hits, res_alarm, res_drop, busy} !==
            {1'b1, sb[0].hits, sb[0].alarm, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_final: valid/hits/alarm/drop/busy got %0b/%0d/%0b/%0b/%0b want 1/%0d/%0b/0/0",
                     res_valid, res_hits, res_alarm, res_drop, busy, sb[0].hits, sb[0].alarm);
        end
        for (int i = 0; i < FRAME_WIN; i++) strobe(1'b1, 1'b0, 1'b0);
        checks++;
        if ({res_hits, res_drop, busy} !== {sb[0].hits, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_strobes: hits/drop/busy got %0d/%0b/%0b want %0d/0/0",
                     res_hits, res_drop, busy, sb[0].hits);
        end
        consume_result("pending_after_stop");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alarm();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_stop_final();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
